// File: rtl/sram32_pkg.sv
// sram32_pkg: shared size encodings, address width default and lane masks for the SRAM load/store unit.
package sram32_pkg;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;
    localparam int ADR_W_DEF = 16;
    localparam logic [3:0] LM_B    = 4'b0001;
    localparam logic [3:0] LM_H_LO = 4'b0011;
    localparam logic [3:0] LM_H_HI = 4'b1100;
    localparam logic [3:0] LM_W    = 4'b1111;
endpackage

// File: rtl/sram32_lane_ext.sv
// sram32_lane_ext: selects the addressed byte/half lane of a read word and sign- or zero-extends it.
module sram32_lane_ext
    import sram32_pkg::*;
(
    input  logic [31:0] mem_dout,
    input  logic [1:0]  adr,
    input  logic [1:0]  size,
    input  logic        sext,
    output logic [31:0] ext
);
    logic [7:0]  w_b;
    logic [15:0] w_h;
    assign w_b = 8'(mem_dout >> {adr, 3'b000});
    assign w_h = 16'(mem_dout >> {adr[1], 4'b0000});
    assign ext = size == SZ_B ? {{24{sext & w_b[7]}}, w_b} :
                 size == SZ_H ? {{16{sext & w_h[15]}}, w_h} : mem_dout;
endmodule

// File: rtl/sram32_lsu.sv
// sram32_lsu: byte/half/word load-store bridge to a combinational-read, posedge-write 32-bit SRAM,
// with one registered, backpressured response per request.
module sram32_lsu
    import sram32_pkg::*;
#(
    parameter int ADR_W = ADR_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_adr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic        w_acc;
    logic        w_bad;
    logic        w_hi;
    logic [3:0]  w_lanes;
    logic [31:0] w_ext;

    assign w_hi  = (req_adr >> ADR_W) != 32'd0;
    assign w_bad = (req_size == SZ_X) | (req_size == SZ_H & req_adr[0]) |
                   (req_size == SZ_W & |req_adr[1:0]) | w_hi;

    // A slot frees up when the held response is being consumed this same cycle.
    assign req_ready = !rst & (!r_rsp_valid | rsp_ready);
    assign w_acc     = req_valid & req_ready;

    assign w_lanes = req_size == SZ_B ? LM_B << req_adr[1:0] :
                     req_size == SZ_H ? (req_adr[1] ? LM_H_HI : LM_H_LO) : LM_W;
    assign mem_en  = w_acc & !w_bad;
    assign mem_we  = (mem_en & req_we) ? w_lanes : 4'b0000;
    assign mem_adr = req_adr;
    assign mem_din = req_size == SZ_B ? {4{req_wdata[7:0]}} :
                     req_size == SZ_H ? {2{req_wdata[15:0]}} : req_wdata;

    sram32_lane_ext u_ext (
        .mem_dout (mem_dout),
        .adr      (req_adr[1:0]),
        .size     (req_size),
        .sext     (req_signed),
        .ext      (w_ext)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_acc) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= (w_bad | req_we) ? '0 : w_ext;
            r_rsp_err   <= w_bad;
        end else if (rsp_ready)
            r_rsp_valid <= 1'b0;

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_sram32_lsu.sv
// tb_sram32_lsu: directed vector table, hand-written backpressure/reset sequences and a randomized
// phase scored against a byte-array reference model.
module tb_sram32_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_adr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_adr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] sram [16384];
    logic [7:0]  ref_mem [65536];
    logic [32:0] q [$];

    sram32_lsu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_adr(req_adr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    assign mem_dout = sram[mem_adr[15:2]];
    always @(posedge clk)
        if (mem_en)
            for (int i = 0; i < 4; i++)
                if (mem_we[i]) sram[mem_adr[15:2]][8*i +: 8] <= mem_din[8*i +: 8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic we, input logic [1:0] size,
                                         input logic sgn, input logic [31:0] adr);
        int n;
        logic [31:0] v;
        logic err;
        n = 1 << size;
        err = (size == 2'b11) || (adr % n) != 0 || adr >= 32'h10000;
        v = '0;
        if (!err && !we) begin
            for (int i = 0; i < n; i++) v |= 32'(ref_mem[adr[15:0] + i]) << (8 * i);
            if (sgn && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8 * n)) - 1);
        end
        return {err, v};
    endfunction

    task automatic model_store(input logic [1:0] size, input logic [31:0] adr, input logic [31:0] wd);
        for (int i = 0; i < (1 << size); i++) ref_mem[adr[15:0] + i] = wd[8*i +: 8];
    endtask

    typedef struct {
        string       tag;
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic        en;
        logic [3:0]  we_exp;
        logic [31:0] din;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    task automatic do_vec(input vec_t v);
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = v.we; req_size = v.size; req_signed = v.sgn;
        req_adr = v.adr; req_wdata = v.wdata;
        #1;
        check({v.tag, ".req_ready"}, 32'(req_ready), 32'd1);
        check({v.tag, ".mem_en"}, 32'(mem_en), 32'(v.en));
        check({v.tag, ".mem_we"}, 32'(mem_we), 32'(v.we_exp));
        if (v.we && v.en) check({v.tag, ".mem_din"}, mem_din, v.din);
        if (v.we && v.en) model_store(v.size, v.adr, v.wdata);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check({v.tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({v.tag, ".rsp_rdata"}, rsp_rdata, v.rdata);
        check({v.tag, ".rsp_err"}, 32'(rsp_err), 32'(v.err));
    endtask

    vec_t tbl [$];

    initial begin
        logic [32:0] e;
        bit acc;
        for (int i = 0; i < 16384; i++) sram[i] = '0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = '0;

        tbl.push_back('{"st_w10",  1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 1, 4'b1111, 32'hDEADBEEF, 32'h0, 0});
        tbl.push_back('{"ld_w10",  0, 2'b10, 0, 32'h10, 32'h0,        1, 4'b0000, 32'h0, 32'hDEADBEEF, 0});
        tbl.push_back('{"st_w04",  1, 2'b10, 0, 32'h04, 32'h11223344, 1, 4'b1111, 32'h11223344, 32'h0, 0});
        tbl.push_back('{"st_b13",  1, 2'b00, 0, 32'h13, 32'h12345680, 1, 4'b1000, 32'h80808080, 32'h0, 0});
        tbl.push_back('{"ld_bs13", 0, 2'b00, 1, 32'h13, 32'h0,        1, 4'b0000, 32'h0, 32'hFFFFFF80, 0});
        tbl.push_back('{"ld_bu13", 0, 2'b00, 0, 32'h13, 32'h0,        1, 4'b0000, 32'h0, 32'h00000080, 0});
        tbl.push_back('{"ld_w10b", 0, 2'b10, 0, 32'h10, 32'h0,        1, 4'b0000, 32'h0, 32'h80ADBEEF, 0});
        tbl.push_back('{"st_h22",  1, 2'b01, 0, 32'h22, 32'hABCD8001, 1, 4'b1100, 32'h80018001, 32'h0, 0});
        tbl.push_back('{"ld_hs22", 0, 2'b01, 1, 32'h22, 32'h0,        1, 4'b0000, 32'h0, 32'hFFFF8001, 0});
        tbl.push_back('{"ld_hu22", 0, 2'b01, 0, 32'h22, 32'h0,        1, 4'b0000, 32'h0, 32'h00008001, 0});
        tbl.push_back('{"ld_bs11", 0, 2'b00, 1, 32'h11, 32'h0,        1, 4'b0000, 32'h0, 32'hFFFFFFBE, 0});
        tbl.push_back('{"er_h05",  1, 2'b01, 0, 32'h05, 32'hFFFFFFFF, 0, 4'b0000, 32'h0, 32'h0, 1});
        tbl.push_back('{"er_w06",  0, 2'b10, 0, 32'h06, 32'h0,        0, 4'b0000, 32'h0, 32'h0, 1});
        tbl.push_back('{"er_sz3",  0, 2'b11, 0, 32'h10, 32'h0,        0, 4'b0000, 32'h0, 32'h0, 1});
        tbl.push_back('{"er_oor",  0, 2'b10, 0, 32'h00010000, 32'h0,  0, 4'b0000, 32'h0, 32'h0, 1});
        tbl.push_back('{"ld_w04",  0, 2'b10, 0, 32'h04, 32'h0,        1, 4'b0000, 32'h0, 32'h11223344, 0});

        // reset state
        req_valid = 1'b1; req_adr = 32'h10; req_size = 2'b10; req_we = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rsp_rdata", rsp_rdata, 32'd0);
        check("rst.rsp_err", 32'(rsp_err), 32'd0);
        check("rst.req_ready", 32'(req_ready), 32'd0);
        check("rst.mem_we", 32'(mem_we), 32'd0);
        req_valid = 1'b0; req_we = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[k]) do_vec(tbl[k]);

        // backpressure: held response, blocked request, then drain+accept with no bubble
        do_vec('{"bp_ld10", 0, 2'b10, 0, 32'h10, 32'h0, 1, 4'b0000, 32'h0, 32'h80ADBEEF, 0});
        rsp_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_adr = 32'h04;
            #1;
            check("bp.req_ready_low", 32'(req_ready), 32'd0);
            check("bp.mem_en_low", 32'(mem_en), 32'd0);
            @(posedge clk);
            #1;
            check("bp.hold_valid", 32'(rsp_valid), 32'd1);
            check("bp.hold_rdata", rsp_rdata, 32'h80ADBEEF);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        check("bp.req_ready_high", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        check("bp.swap_valid", 32'(rsp_valid), 32'd1);
        check("bp.swap_rdata", rsp_rdata, 32'h11223344);
        req_adr = 32'h10;
        @(posedge clk);
        #1;
        check("bp.b2b_valid", 32'(rsp_valid), 32'd1);
        check("bp.b2b_rdata", rsp_rdata, 32'h80ADBEEF);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bp.drained", 32'(rsp_valid), 32'd0);

        // reset with a held response and a blocked store pending
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_adr = 32'h04;
        @(posedge clk);
        #1;
        check("mr.valid_before", 32'(rsp_valid), 32'd1);
        req_we = 1'b1; req_adr = 32'h10; req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mr.valid_async", 32'(rsp_valid), 32'd0);
        check("mr.rdata_async", rsp_rdata, 32'd0);
        check("mr.mem_we", 32'(mem_we), 32'd0);
        check("mr.mem_en", 32'(mem_en), 32'd0);
        check("mr.req_ready", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        do_vec('{"mr_ld10", 0, 2'b10, 0, 32'h10, 32'h0, 1, 4'b0000, 32'h0, 32'h80ADBEEF, 0});

        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;

        // randomized phase against the reference model
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rsp_ready = ($urandom_range(3) != 0);
            if (!req_valid && $urandom_range(4) != 0) begin
                req_valid = 1'b1;
                req_we = 1'($urandom_range(1));
                req_size = ($urandom_range(15) == 0) ? 2'b11 : 2'($urandom_range(2));
                req_signed = 1'($urandom_range(1));
                req_adr = 32'($urandom_range(63));
                if ($urandom_range(15) == 0) req_adr = req_adr | (32'd1 << $urandom_range(31, 16));
                req_wdata = $urandom;
            end
            #1;
            check("rnd.rsp_valid", 32'(rsp_valid), 32'(q.size() != 0));
            check("rnd.req_ready", 32'(req_ready), 32'(q.size() == 0 || rsp_ready));
            if (rsp_valid && rsp_ready && q.size() != 0) begin
                check("rnd.rsp_rdata", rsp_rdata, q[0][31:0]);
                check("rnd.rsp_err", 32'(rsp_err), 32'(q[0][32]));
                void'(q.pop_front());
            end
            acc = req_valid && req_ready;
            if (acc) begin
                e = model(req_we, req_size, req_signed, req_adr);
                check("rnd.mem_en", 32'(mem_en), 32'(!e[32]));
                q.push_back(e);
                if (req_we && !e[32]) model_store(req_size, req_adr, req_wdata);
            end
            @(posedge clk);
            #1;
            if (acc) req_valid = 1'b0;
        end

        req_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            rsp_ready = 1'b1;
            #1;
            if (rsp_valid && q.size() != 0) begin
                check("drain.rsp_rdata", rsp_rdata, q[0][31:0]);
                check("drain.rsp_err", 32'(rsp_err), 32'(q[0][32]));
                void'(q.pop_front());
            end
        end
        check("drain.empty", 32'(q.size()), 32'd0);
        check("drain.valid", 32'(rsp_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sram32_lsu.md
Name: sram32_lsu

Overview:
- Initiator-side bridge that drives the 32-bit byte-enabled SRAM port: the SRAM's combinational-read, posedge-write, 16384x32 (64 KiB) array.
- Accepts byte/half/word load and store requests on a valid/ready channel.
- Generates per-lane write enables with replicated store data.
- Extracts and sign- or zero-extends load data, and returns one registered response per request on a backpressured valid/ready channel.
- Sits between the core's load/store stage and the data SRAM.

Parameters:
- ADR_W, 16, number of implemented byte-address bits. Addresses with any bit at or above ADR_W set are out of range.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  size encoding: 00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  sign-extend load data (ignored for word and for stores).
- req_adr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, illegal-size or out-of-range request.
- mem_en  out  1  SRAM enable.
- mem_we  out  4  SRAM byte write enables.
- mem_adr  out  32  SRAM byte address.
- mem_din  out  32  SRAM write data.
- mem_dout  in  32  SRAM combinational read data.

Behaviour:
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_err=0. mem_en, mem_we and req_ready are forced to 0 while rst is high.
- Ready rule: req_ready = !rst & (!rsp_valid | rsp_ready). This gives one-deep buffering and a throughput of 1 request per cycle when the consumer is always ready.
- Accept: acc = req_valid & req_ready.
- Memory port is combinational from the request:
  - mem_adr = req_adr.
  - mem_en = acc & !bad.
  - mem_we = store lanes when req_we, else 0.
- Error conditions, bad =
  - size==11, or
  - half with adr[0]=1, or
  - word with adr[1:0]!=0, or
  - any of req_adr[31:ADR_W] != 0.
- On a bad request: no SRAM access (mem_en=0, mem_we=0). The response has err=1 and rdata=0.
- Store lanes:
  - Byte: bit adr[1:0] set in mem_we.
  - Half: lanes {1,0} when adr[1]=0, {3,2} when adr[1]=1.
  - Word: 1111.
- Store data replication:
  - Byte: mem_din = {4{wdata[7:0]}}.
  - Half: mem_din = {2{wdata[15:0]}}.
  - Word: mem_din = wdata.
- Load: mem_dout is sampled at the accept edge, with no extra cycle because the SRAM read is combinational.
  - The lane is selected by adr[1:0] (byte) or adr[1] (half).
  - The lane is extended by req_signed; a word load is returned unchanged.
- Response register, updated on posedge clk:
  - If acc: rsp_valid←1; rsp_rdata and rsp_err as computed.
  - Else if rsp_ready: rsp_valid←0.
  - rsp_rdata and rsp_err hold while rsp_valid=1 and rsp_ready=0.
- Latency: the response is visible the cycle after acceptance.
- A store's SRAM write commits at the same edge the response registers, so a load accepted the next cycle sees the stored data.
- Simultaneous drain and accept (rsp_valid & rsp_ready & req_valid): the old response is consumed and the new one is loaded at the same edge, with no bubble.
- Reset asserted mid-operation: the held response is discarded. No write occurs in any cycle where rst is high, because mem_en=0.

Decomposition:
- Package sram32_pkg holds:
  - size constants SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10, SZ_X=2'b11;
  - the ADR_W default;
  - lane-mask helper constants.
- One combinational sub-module, sram32_lane_ext: inputs mem_dout, adr[1:0], size and signed; output is the extended 32-bit load value.
- Lane decode, error decode and the response register stay in the top module.

Test Plan:
1. Store word 0xDEADBEEF at 0x10, then load word at 0x10 on the next cycle:
   - store: mem_we=1111;
   - load: rsp_rdata=0xDEADBEEF, rsp_err=0, response one cycle after acceptance.
2. Store byte 0x80 at 0x13, then two loads at 0x13:
   - store: mem_we=1000, mem_din=0x80808080;
   - signed byte load: 0xFFFFFF80;
   - unsigned byte load: 0x00000080.
3. Store half 0x8001 at 0x22, then half loads at 0x22:
   - store: mem_we=1100;
   - signed: 0xFFFF8001;
   - unsigned: 0x00008001.
4. Error requests, each of which gives rsp_err=1, rsp_rdata=0, mem_en=0 and no SRAM change:
   - half store at 0x05;
   - word load at 0x06;
   - size=11 load;
   - load at 0x00010000.
5. Backpressure: hold rsp_ready=0 after one load.
   - req_ready=0 and the response is held stable.
   - Raise rsp_ready with req_valid=1: drain and accept happen in the same edge, and back-to-back responses follow with no bubble.
6. Assert rst while rsp_valid=1 and a store is pending:
   - rsp_valid drops immediately (asynchronously).
   - mem_we stays 0 and no write lands.
   - After release, the first request is accepted normally.
